// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug trace input block: frame mode encoding,
// frame lengths in nibbles, receiver state encoding and the record layout.
// Optional feature macro used by debug_input: DEBUG_INPUT_STATS_EN.
// -----------------------------------------------------------------------------
package debug_pkg;

    typedef enum logic [1:0] {
        PC             = 2'd0,
        PC_INSTR       = 2'd1,
        PC_INSTR_WDATA = 2'd2,
        ILLEGAL        = 2'd3
    } dbg_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } dbg_state_e;

    localparam int unsigned LEN_PC             = 8;
    localparam int unsigned LEN_PC_INSTR       = 16;
    localparam int unsigned LEN_PC_INSTR_WDATA = 24;

    // Nibble counter width and assembled frame width ({wdata, instr, pc}).
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned FRAME_W = 96;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wdata;
    } dbg_record_t;

    // Number of nibbles in a frame of the given mode. ILLEGAL never starts a
    // frame, so its value is irrelevant.
    function automatic logic [CNT_W-1:0] frame_len(input dbg_mode_e m);
        case (m)
            PC:             return CNT_W'(LEN_PC);
            PC_INSTR:       return CNT_W'(LEN_PC_INSTR);
            PC_INSTR_WDATA: return CNT_W'(LEN_PC_INSTR_WDATA);
            default:        return CNT_W'(LEN_PC);
        endcase
    endfunction

endpackage

// File: rtl/debug_input_if.sv
// -----------------------------------------------------------------------------
// debug_input_if
// Bus between the nibble transmitter / record consumer (master) and the
// debug_input receiver (slave).
//   mode        frame format, sampled on the first nibble of a frame
//   nib_valid   nibble strobe, high while a frame is being driven
//   nib_data    serial nibble, least significant nibble first
//   rec_valid   a reconstructed record is held
//   rec_ready   consumer accepts the held record
//   rec_mode    mode of the held record
//   rec_pc/rec_instr/rec_wdata  record fields
//   err_abort   one-cycle pulse: frame truncated or illegal mode
//   err_ovf     one-cycle pulse: completed frame dropped, record held
//
// Record handshake: a transfer happens on a rising edge where rec_valid and
// rec_ready are both high. While rec_valid is high and rec_ready is low the
// record outputs do not change. rec_valid does not depend on rec_ready.
// The nibble side has no backpressure: every cycle with nib_valid high
// delivers one nibble.
// -----------------------------------------------------------------------------
interface debug_input_if;
    logic [1:0]  mode;
    logic        nib_valid;
    logic [3:0]  nib_data;
    logic        rec_valid;
    logic        rec_ready;
    logic [1:0]  rec_mode;
    logic [31:0] rec_pc;
    logic [31:0] rec_instr;
    logic [31:0] rec_wdata;
    logic        err_abort;
    logic        err_ovf;

    modport master (
        output mode, nib_valid, nib_data, rec_ready,
        input  rec_valid, rec_mode, rec_pc, rec_instr, rec_wdata,
               err_abort, err_ovf
    );

    modport slave (
        input  mode, nib_valid, nib_data, rec_ready,
        output rec_valid, rec_mode, rec_pc, rec_instr, rec_wdata,
               err_abort, err_ovf
    );
endinterface

// File: rtl/debug_nibble_deser.sv
// -----------------------------------------------------------------------------
// debug_nibble_deser
// Nibble counter and frame assembly register. Nibble k is placed at bits
// [4k+3:4k] of the 96-bit {wdata, instr, pc} frame.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start_i     first nibble of a frame: restart assembly with nib_i at 0
//   store_i     subsequent nibble: place nib_i at the current count
//   clear_i     discard the partial frame
//   nib_i       incoming nibble
//   len_i       length of the frame in progress, in nibbles
//   done_o      this store completes the frame (combinational)
//   frame_o     assembled frame including the current nibble (combinational),
//               valid for loading when done_o is high
// -----------------------------------------------------------------------------
module debug_nibble_deser
    import debug_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               store_i,
    input  logic               clear_i,
    input  logic [3:0]         nib_i,
    input  logic [CNT_W-1:0]   len_i,
    output logic               done_o,
    output logic [FRAME_W-1:0] frame_o
);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME_W-1:0] data_q, data_d;
    logic [FRAME_W-1:0] placed;

    always_comb begin
        placed  = FRAME_W'(nib_i) << {cnt_q, 2'b00};
        frame_o = data_q | placed;
        done_o  = 1'b0;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (clear_i) begin
            cnt_d  = '0;
            data_d = '0;
        end else if (start_i) begin
            // Starting from zero keeps the fields a short frame never
            // reaches at zero.
            cnt_d  = CNT_W'(1);
            data_d = FRAME_W'(nib_i);
        end else if (store_i) begin
            if (cnt_q == len_i - CNT_W'(1)) begin
                done_o = 1'b1;
                cnt_d  = '0;
                data_d = '0;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
                data_d = frame_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/debug_input.sv
// -----------------------------------------------------------------------------
// debug_input
// Receives serial debug trace frames (PC / PC+instr / PC+instr+wdata) one
// nibble per cycle and presents each completed frame as a record behind a
// valid/ready output register.
// Ports:
//   clk, rst    clock, synchronous active-high reset (highest priority)
//   bus         debug_input_if.slave: nibble input, record output, errors
//   state_o     current receiver state (dbg_state_e: 0 IDLE, 1 RECV)
//   frame_cnt   (DEBUG_INPUT_STATS_EN only) records loaded
//   drop_cnt    (DEBUG_INPUT_STATS_EN only) aborts + overflows, saturating
// Optional feature macro: DEBUG_INPUT_STATS_EN.
// -----------------------------------------------------------------------------
module debug_input
    import debug_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    debug_input_if.slave bus,
    output logic         state_o
`ifdef DEBUG_INPUT_STATS_EN
    ,
    output logic [31:0]  frame_cnt,
    output logic [15:0]  drop_cnt
`endif
);

    dbg_state_e  state_q;
    dbg_mode_e   mode_q;
    logic        skip_q;
    logic        rec_valid_q;
    dbg_mode_e   rec_mode_q;
    dbg_record_t rec_q;
    logic        err_abort_q;
    logic        err_ovf_q;

    logic               start;
    logic               illegal;
    logic               store;
    logic               trunc;
    logic               done;
    logic               load;
    logic               ovf;
    logic [CNT_W-1:0]   len;
    logic [FRAME_W-1:0] frame;

    // skip_q: an illegal-mode frame was seen; its nibbles are ignored until
    // nib_valid has been low for a cycle.
    always_comb begin
        start   = 1'b0;
        illegal = 1'b0;
        store   = 1'b0;
        trunc   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (!skip_q && bus.nib_valid) begin
                if (bus.mode == ILLEGAL) illegal = 1'b1;
                else                     start   = 1'b1;
            end
        end else begin
            if (bus.nib_valid) store = 1'b1;
            else               trunc = 1'b1;
        end
        len  = frame_len(mode_q);
        // A completion may load when the register is empty or being emptied
        // in the same cycle; otherwise it is dropped.
        load = done && (!rec_valid_q || bus.rec_ready);
        ovf  = done && rec_valid_q && !bus.rec_ready;
    end

    debug_nibble_deser u_deser (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .store_i (store),
        .clear_i (trunc),
        .nib_i   (bus.nib_data),
        .len_i   (len),
        .done_o  (done),
        .frame_o (frame)
    );

`ifdef DEBUG_INPUT_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] drop_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= PC;
            skip_q      <= 1'b0;
            rec_valid_q <= 1'b0;
            rec_mode_q  <= PC_INSTR;
            rec_q       <= '0;
            err_abort_q <= 1'b0;
            err_ovf_q   <= 1'b0;
`ifdef DEBUG_INPUT_STATS_EN
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
`endif
        end else begin
            err_abort_q <= illegal || trunc;
            err_ovf_q   <= ovf;

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RECV;
                        mode_q  <= dbg_mode_e'(bus.mode);
                    end else if (illegal) begin
                        skip_q <= 1'b1;
                    end else if (skip_q && !bus.nib_valid) begin
                        skip_q <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (trunc || done) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            if (load) begin
                rec_valid_q <= 1'b1;
                rec_mode_q  <= mode_q;
                rec_q.pc    <= frame[31:0];
                rec_q.instr <= frame[63:32];
                rec_q.wdata <= frame[95:64];
            end else if (rec_valid_q && bus.rec_ready) begin
                rec_valid_q <= 1'b0;
            end

`ifdef DEBUG_INPUT_STATS_EN
            if (load) frame_cnt_q <= frame_cnt_q + 32'd1;
            if ((illegal || trunc || ovf) && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
`endif
        end
    end

    assign bus.rec_valid = rec_valid_q;
    assign bus.rec_mode  = rec_mode_q;
    assign bus.rec_pc    = rec_q.pc;
    assign bus.rec_instr = rec_q.instr;
    assign bus.rec_wdata = rec_q.wdata;
    assign bus.err_abort = err_abort_q;
    assign bus.err_ovf   = err_ovf_q;
    assign state_o       = state_q;

`ifdef DEBUG_INPUT_STATS_EN
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_debug_input.sv
// -----------------------------------------------------------------------------
// tb_debug_input
// Drives directed and randomized nibble frames into debug_input and compares
// every cycle against a frame-level reference model (nibble queue per frame,
// record register, error pulses). Records accepted by the consumer are also
// checked against an expected queue.
// -----------------------------------------------------------------------------
module tb_debug_input;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    logic state_o;
`ifdef DEBUG_INPUT_STATS_EN
    logic [31:0] frame_cnt;
    logic [15:0] drop_cnt;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    debug_input_if bus ();

    debug_input dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_o   (state_o)
`ifdef DEBUG_INPUT_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic        m_busy;
    logic        m_skip;
    logic [1:0]  m_mode;
    logic [3:0]  m_nibs[$];
    logic        m_rv;
    logic [1:0]  m_rmode;
    logic [31:0] m_pc, m_instr, m_wdata;
    logic        m_abort, m_ovf;
    logic [31:0] m_frames;
    logic [15:0] m_drops;

    // Scoreboard of loaded records: {mode, wdata, instr, pc}.
    logic [97:0] exp_q[$];

    task automatic model_reset();
        m_busy = 0; m_skip = 0; m_mode = 0; m_nibs.delete();
        m_rv = 0; m_rmode = 2'd1; m_pc = 0; m_instr = 0; m_wdata = 0;
        m_abort = 0; m_ovf = 0; m_frames = 0; m_drops = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [1:0] m, input logic [3:0] d, input logic rdy);
        logic        done;
        logic [95:0] a;
        done = 0; m_abort = 0; m_ovf = 0;
        if (!m_busy) begin
            if (m_skip) begin
                if (!v) m_skip = 0;
            end else if (v) begin
                if (m == 2'd3) begin
                    m_abort = 1; m_skip = 1;
                end else begin
                    m_busy = 1; m_mode = m; m_nibs.delete(); m_nibs.push_back(d);
                end
            end
        end else if (v) begin
            m_nibs.push_back(d);
            if (m_nibs.size() == 8 * (int'(m_mode) + 1)) begin
                done = 1; m_busy = 0;
            end
        end else begin
            m_abort = 1; m_busy = 0; m_nibs.delete();
        end

        if (done) begin
            if (!m_rv || rdy) begin
                a = '0;
                foreach (m_nibs[k]) a[4*k +: 4] = m_nibs[k];
                m_rv = 1; m_rmode = m_mode;
                m_pc = a[31:0]; m_instr = a[63:32]; m_wdata = a[95:64];
                m_frames++;
                exp_q.push_back({m_mode, a});
            end else begin
                m_ovf = 1;
            end
        end else if (m_rv && rdy) begin
            m_rv = 0;
        end
        if ((m_abort || m_ovf) && m_drops != 16'hFFFF) m_drops++;
    endtask

    task automatic compare_all();
        check("rec_valid", bus.rec_valid, m_rv);
        check("err_abort", bus.err_abort, m_abort);
        check("err_ovf",   bus.err_ovf,   m_ovf);
        check("rec_mode",  bus.rec_mode,  m_rmode);
        check("rec_pc",    bus.rec_pc,    m_pc);
        check("rec_instr", bus.rec_instr, m_instr);
        check("rec_wdata", bus.rec_wdata, m_wdata);
        check("state",     state_o,       m_busy);
`ifdef DEBUG_INPUT_STATS_EN
        check("frame_cnt", frame_cnt, m_frames);
        check("drop_cnt",  drop_cnt,  m_drops);
`endif
    endtask

    // ---------------- driver tasks ----------------
    int ready_pol = 1; // 0: low, 1: high, 2: random

    task automatic step(input logic v, input logic [1:0] m, input logic [3:0] d);
        logic        rr;
        logic [97:0] e;
        case (ready_pol)
            0:       rr = 1'b0;
            1:       rr = 1'b1;
            default: rr = 1'($urandom_range(0, 1));
        endcase
        bus.nib_valid = v;
        bus.mode      = m;
        bus.nib_data  = d;
        bus.rec_ready = rr;
        if (bus.rec_valid && rr) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc",    bus.rec_pc,    e[31:0]);
                check("sb_instr", bus.rec_instr, e[63:32]);
                check("sb_wdata", bus.rec_wdata, e[95:64]);
                check("sb_mode",  bus.rec_mode,  32'(e[97:96]));
            end
        end
        model_step(v, m, d, rr);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    endtask

    // Nibbles first..first+count-1 of frame v; only nibble 0 carries the real
    // mode, later nibbles carry random mode values that must be ignored.
    task automatic send_nibbles(input logic [1:0] m, input logic [95:0] v, input int first, input int count);
        for (int k = first; k < first + count; k++)
            step(1'b1, (k == 0) ? m : 2'($urandom_range(0, 3)), v[4*k +: 4]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    task automatic rand_frame();
        logic [1:0]  m;
        logic [95:0] v;
        int          len, n, gap;
        m   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        v   = {$urandom, $urandom, $urandom};
        len = (m == 2'd3) ? int'($urandom_range(1, 6)) : 8 * (int'(m) + 1);
        n   = len;
        if (m != 2'd3 && $urandom_range(0, 7) == 0) n = $urandom_range(1, len - 1);
        send_nibbles(m, v, 0, n);
        gap = $urandom_range(0, 2);
        if (n != len && gap == 0) gap = 1;
        idle(gap);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        bus.nib_valid = 0; bus.mode = 0; bus.nib_data = 0; bus.rec_ready = 0;
        do_reset();
        check("reset_mode", bus.rec_mode, 32'd1);
        check("reset_valid", bus.rec_valid, 32'd0);

        // PC+instr frame, consumer always ready.
        ready_pol = 1;
        send_nibbles(2'd1, {32'h0, 32'h02800C0C, 32'h1C000004}, 0, 16);
        check("d1_valid", bus.rec_valid, 32'd1);
        check("d1_pc",    bus.rec_pc,    32'h1C000004);
        check("d1_instr", bus.rec_instr, 32'h02800C0C);
        check("d1_wdata", bus.rec_wdata, 32'h0);
        idle(2);

        // Truncated PC+instr+wdata frame, then a full one.
        send_nibbles(2'd2, {32'hDEADBEEF, 32'h11111111, 32'h22222222}, 0, 11);
        idle(1);
        check("d2_abort", bus.err_abort, 32'd1);
        check("d2_novalid", bus.rec_valid, 32'd0);
        idle(1);
        send_nibbles(2'd2, {32'hDEADBEEF, 32'h33333333, 32'h44444444}, 0, 24);
        check("d2_wdata", bus.rec_wdata, 32'hDEADBEEF);
        check("d2_pc",    bus.rec_pc,    32'h44444444);
        idle(2);

        // Overflow: consumer stalled, second frame dropped.
        ready_pol = 0;
        send_nibbles(2'd0, {64'h0, 32'h100}, 0, 8);
        idle(1);
        send_nibbles(2'd0, {64'h0, 32'h104}, 0, 8);
        check("d3_ovf", bus.err_ovf, 32'd1);
        check("d3_pc",  bus.rec_pc,  32'h100);
        idle(1);
        ready_pol = 1;
        idle(2);

        // Completion coincident with a handshake.
        ready_pol = 0;
        send_nibbles(2'd0, {64'h0, 32'h200}, 0, 8);
        idle(1);
        send_nibbles(2'd0, {64'h0, 32'h204}, 0, 7);
        ready_pol = 1;
        send_nibbles(2'd0, {64'h0, 32'h204}, 7, 1);
        check("d4_pc",    bus.rec_pc,    32'h204);
        check("d4_valid", bus.rec_valid, 32'd1);
        check("d4_noovf", bus.err_ovf,   32'd0);
        idle(2);

        // Illegal mode, ignored nibbles, gap, then a PC frame.
        step(1'b1, 2'd3, 4'h5);
        check("d5_abort", bus.err_abort, 32'd1);
        send_nibbles(2'd3, 96'h0, 1, 4);
        idle(1);
        send_nibbles(2'd0, {64'h0, 32'h8}, 0, 8);
        check("d5_pc", bus.rec_pc, 32'h8);
        idle(2);

        // Reset in the middle of a PC+instr+wdata frame.
        send_nibbles(2'd2, {32'hCAFEF00D, 32'h55555555, 32'h66666666}, 0, 6);
        bus.nib_valid = 1'b1; bus.nib_data = 4'h6;
        do_reset();
        check("d6_abort", bus.err_abort, 32'd0);
        check("d6_valid", bus.rec_valid, 32'd0);
        check("d6_mode",  bus.rec_mode,  32'd1);
`ifdef DEBUG_INPUT_STATS_EN
        check("d6_drop", drop_cnt, 32'd0);
`endif
        idle(2);

        // Randomized frames, back-to-back or with gaps, random backpressure.
        ready_pol = 2;
        for (int i = 0; i < 200; i++) rand_frame();
        ready_pol = 1;
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debug_input.md
DEBUG_INPUT -- requirements
Module: debug_input

Interface
REQ-001 Parameters: none; all frame geometry comes from debug_pkg constants.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mode  in  2  frame format: 0 = PC only, 1 = PC+instr, 2 = PC+instr+wdata, 3 = illegal; sampled on the first nibble of each frame.
REQ-005 nib_valid  in  1  nibble strobe; high while the transmitter is driving a frame.
REQ-006 nib_data  in  4  serial nibble, least significant nibble first.
REQ-007 rec_valid  out  1  a reconstructed record is held in the output register.
REQ-008 rec_ready  in  1  consumer accepts the record when rec_valid && rec_ready.
REQ-009 rec_mode  out  2  mode of the held record.
REQ-010 rec_pc, rec_instr, rec_wdata  out  32 each  reconstructed fields.
REQ-011 err_abort  out  1  one-cycle pulse when a frame is truncated.
REQ-012 err_ovf  out  1  one-cycle pulse when a completed frame is dropped because the output register is full.

Function
REQ-013 Frame length SHALL be 8, 16 or 24 nibbles for mode 0, 1 or 2; nibble k SHALL land in bits [4k+3:4k] of {wdata, instr, pc}.
REQ-014 States SHALL be IDLE and RECV; a 5-bit nibble counter and a 96-bit shift register hold partial data.
REQ-015 IDLE: nib_valid=1 with a legal mode -> latch mode, store nibble 0, cnt=1, go to RECV.
REQ-016 IDLE: nib_valid=1 with mode==3 -> stay in IDLE, pulse err_abort, ignore nibbles until nib_valid has been low for at least one cycle.
REQ-017 RECV: nib_valid=1 -> store the nibble at index cnt and increment cnt; the last nibble (cnt==len-1) completes the frame and returns to IDLE.
REQ-018 RECV: nib_valid=0 before the last nibble -> discard the partial frame, pulse err_abort, go to IDLE.
REQ-019 Completion loads the output register; rec_valid SHALL rise the cycle after the last nibble (latency 1).
REQ-020 Unused fields SHALL be zero: mode 0 gives rec_instr=rec_wdata=0; mode 1 gives rec_wdata=0.
REQ-021 A frame completing while rec_valid=1 and rec_ready=0 SHALL be dropped, pulse err_ovf, and leave the held record unchanged.
REQ-022 A frame completing in the same cycle as a handshake SHALL replace the record, with rec_valid staying 1 and no err_ovf.
REQ-023 Handshake without a new completion SHALL clear rec_valid next cycle; outputs SHALL be stable while rec_valid && !rec_ready.
REQ-024 Back-to-back frames: nib_valid held high after a last nibble SHALL start a new frame on the next nibble, with no idle cycle required.
REQ-025 A mode change mid-frame SHALL be ignored until the next frame start.

Reset
REQ-026 rst SHALL force IDLE, cnt=0, shift register=0, rec_valid=0, rec_mode=1, rec_pc/instr/wdata=0, err_abort=err_ovf=0, and counters=0.
REQ-027 rst asserted mid-frame SHALL discard the partial frame without an err_abort pulse; rst has priority over every other event.

Configuration
REQ-028 Macro DEBUG_INPUT_STATS_EN defined: add outputs frame_cnt (32-bit, +1 per record loaded) and drop_cnt (16-bit, +1 per err_abort or err_ovf, saturating at 0xFFFF).
REQ-029 Macro undefined: neither port nor counter exists; all other behaviour is identical.

Structure
REQ-030 debug_pkg SHALL hold the dbg_mode_e enum (PC, PC_INSTR, PC_INSTR_WDATA, ILLEGAL), the frame lengths 8/16/24, and the packed dbg_record_t {pc, instr, wdata}.
REQ-031 One sub-module, debug_nibble_deser, SHALL implement the shift register and counter and report done; debug_input SHALL own the FSM and output register.

Verification
REQ-032 mode=1, 16 nibbles of pc=0x1C000004, instr=0x02800C0C, rec_ready=1 -> rec_valid one cycle after nibble 15; fields match; rec_wdata=0.
REQ-033 mode=2, wdata=0xDEADBEEF, nib_valid drops after nibble 10 -> err_abort pulse; no rec_valid; the next full frame is received correctly.
REQ-034 rec_ready=0, two mode-0 frames pc=0x100 then pc=0x104 -> err_ovf on the second frame; rec_pc stays 0x100.
REQ-035 Completion coincident with a handshake, pc=0x200 held and 0x204 completing -> rec_pc=0x204, rec_valid continuously 1, no err_ovf.
REQ-036 mode=3 start, 5 nibbles, gap, then a mode-0 frame pc=0x8 -> one err_abort; then a record with pc=0x8.
REQ-037 rst asserted at nibble 6 of a mode-2 frame -> all outputs at reset values; no pulse; with DEBUG_INPUT_STATS_EN, drop_cnt=0.
